// File: rtl/pe_row_psum_collector.sv
// Partial-sum collector at the output of a 16-PE row: reduces each beat by mode,
// accumulates with saturation over a programmed window, then hands off via valid/ready.
module pe_row_psum_collector #(
  parameter int unsigned ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [7:0]              acc_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [15:0][15:0]       product,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0][ACC_W-1:0]  psum,
  output logic [4:0]              out_lanes,
  output logic                    sat,
  output logic                    busy
);

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  state_e                   state_q, state_d;
  logic [1:0]               mode_q;
  logic [7:0]               len_q, count_q;
  logic [15:0][ACC_W-1:0]   acc_q, acc_next;
  logic                     sat_q, sat_beat;
  logic [4:0]               lanes_q;

  logic                     beat_fire, last_beat, start_acc;
  logic [15:0][ACC_W-1:0]   red;
  logic [7:0][16:0]         pair;
  logic [19:0]              row_sum;
  logic [ACC_W:0]           wide;

  localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  assign beat_fire = in_valid && in_ready;
  assign last_beat = beat_fire && ((count_q + 8'd1) == len_q);
  // A start in HOLD only counts when it coincides with the result being consumed.
  assign start_acc = start && ((state_q == StIdle) || ((state_q == StHold) && out_ready));

  // Beat reduction; latched mode 3 was already folded to per-lane.
  always_comb begin
    red     = '0;
    pair    = '0;
    row_sum = '0;
    unique case (mode_q)
      2'd1: begin
        for (int k = 0; k < 8; k++) begin
          pair[k] = {product[2*k][15], product[2*k]} + {product[2*k+1][15], product[2*k+1]};
          red[k]  = {{(ACC_W-17){pair[k][16]}}, pair[k]};
        end
      end
      2'd2: begin
        for (int i = 0; i < 16; i++) begin
          row_sum = row_sum + {{4{product[i][15]}}, product[i]};
        end
        red[0] = {{(ACC_W-20){row_sum[19]}}, row_sum};
      end
      default: begin
        for (int i = 0; i < 16; i++) begin
          red[i] = {{(ACC_W-16){product[i][15]}}, product[i]};
        end
      end
    endcase
  end

  // One guard bit catches overflow; clamp toward the overflowing sign.
  always_comb begin
    acc_next = acc_q;
    sat_beat = 1'b0;
    wide     = '0;
    for (int i = 0; i < 16; i++) begin
      wide = {acc_q[i][ACC_W-1], acc_q[i]} + {red[i][ACC_W-1], red[i]};
      if (wide[ACC_W] != wide[ACC_W-1]) begin
        acc_next[i] = wide[ACC_W] ? AccMin : AccMax;
        sat_beat    = 1'b1;
      end else begin
        acc_next[i] = wide[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StAcc;
      StAcc:   if (last_beat) state_d = StHold;
      StHold:  if (out_ready) state_d = start ? StAcc : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StAcc);
    out_valid = (state_q == StHold);
    busy      = (state_q != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= 2'd0;
      len_q   <= 8'd0;
      count_q <= 8'd0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      lanes_q <= 5'd0;
    end else if (start_acc) begin
      mode_q  <= (mode == 2'd3) ? 2'd0 : mode;
      len_q   <= (acc_len == 8'd0) ? 8'd1 : acc_len;
      count_q <= 8'd0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      lanes_q <= (mode == 2'd2) ? 5'd1 : (mode == 2'd1) ? 5'd8 : 5'd16;
    end else if (beat_fire) begin
      acc_q   <= acc_next;
      sat_q   <= sat_q | sat_beat;
      count_q <= count_q + 8'd1;
    end
  end

  assign psum      = acc_q;
  assign out_lanes = lanes_q;
  assign sat       = sat_q;

endmodule
